instr_loader: RTL and testbench

Host-side writer for the processor's instruction memory. It accepts a program as a byte stream over a valid/ready handshake and packs byte pairs into 16-bit instructions, high byte first. It then issues one write per instruction to sequential addresses starting at 0 and reports completion with a running checksum. It sits between the debug/UART byte source and the write port of a writable instruction RAM; the fetch path reads the same RAM by PC.

---
 rtl/instr_loader.sv | 149 ++++++++++++++
 tb/tb_instr_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: packs a host byte stream into 16-bit instructions (high byte
// first) and writes them to sequential instruction-memory addresses from 0,
// keeping a running 16-bit checksum of every written word.
module instr_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [15:0]   wr_addr,
  output logic [15:0]   wr_data,
  output logic          busy,
  output logic          done,
  output logic [15:0]   checksum
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic [15:0]   checksum_q, checksum_d;
  logic          byte_ready_q, byte_ready_d;
  logic          wr_en_q, wr_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [AW:0]   len_clamp_s;
  logic          handshake_s;

  assign len_clamp_s = (load_len > DEPTH_W) ? DEPTH_W : load_len;
  assign handshake_s = byte_valid && byte_ready_q;

  // Next-state and datapath updates; status outputs derive from the next state
  // so they are registered and valid in the same cycle as the state they flag.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    checksum_d = checksum_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          len_d      = len_clamp_s;
          cnt_d      = '0;
          checksum_d = 16'h0000;
          state_d    = (len_clamp_s == '0) ? ST_DONE : ST_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HI: begin
        if (handshake_s) begin
          hi_d    = byte_in;
          state_d = ST_LO;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_LO: begin
        if (handshake_s) begin
          wr_addr_d = {{(16-AW){1'b0}}, cnt_q};
          wr_data_d = {hi_q, byte_in};
          state_d   = ST_WRITE;
        end else begin
          state_d = ST_LO;
        end
      end
      ST_WRITE: begin
        checksum_d = checksum_q + wr_data_q;
        if ({1'b0, cnt_q} == (len_q - ONE_W)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + {{(AW-1){1'b0}}, 1'b1};
          state_d = ST_HI;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    byte_ready_d = (state_d == ST_HI) || (state_d == ST_LO);
    wr_en_d      = (state_d == ST_WRITE);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  // State and datapath registers; reset overrides everything and aborts a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      hi_q         <= 8'h00;
      wr_addr_q    <= 16'h0000;
      wr_data_q    <= 16'h0000;
      checksum_q   <= 16'h0000;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      checksum_q   <= checksum_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [8:0]  load_len;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  int tests_run = 0;
  int fails = 0;

  logic [7:0]  stim [$];
  logic [15:0] wa_q [$];
  logic [15:0] wd_q [$];
  int cyc_cnt = 0;
  int done_cnt = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int rdy_viol = 0;

  instr_loader #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Monitor: records every write and done pulse, away from the active edge.
  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      last_wr_cyc <= cyc_cnt;
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc_cnt;
    end
    if ((wr_en === 1'b1 || done === 1'b1) && byte_ready !== 1'b0)
      rdy_viol <= rdy_viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [8:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  // mode 0: valid always; 1: valid 1,0,0,1 pattern; 2: valid always plus load_start pulses
  task automatic stream(input int n, input int mode);
    int idx = 0;
    int cyc = 0;
    logic hs;
    while (idx < n && cyc < 4000) begin
      case (mode)
        1:       byte_valid = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: byte_valid = 1'b1;
      endcase
      if (mode == 2) begin
        load_start = (cyc % 2) == 0;
        load_len   = 9'd1;
      end
      byte_in = stim[idx];
      hs = byte_valid && byte_ready;
      tick();
      if (hs) idx++;
      cyc++;
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
    tests_run++;
    if (idx !== n) begin
      fails++;
      $display("FAIL stream_accept: accepted %0d bytes, expected %0d", idx, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    tests_run++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, c);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL after_done: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic check_three(input string name, input int wb, input int db);
    logic [15:0] exp_d [3] = '{16'h9205, 16'h943B, 16'h968F};
    tests_run++;
    if (wa_q.size() - wb !== 3) begin
      fails++;
      $display("FAIL %s_nwr: got %0d writes, expected 3", name, wa_q.size() - wb);
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (wa_q[wb+k] !== 16'(k) || wd_q[wb+k] !== exp_d[k]) begin
          fails++;
          $display("FAIL %s_wr%0d: got %h@%h, expected %h@%h", name, k,
                   wd_q[wb+k], wa_q[wb+k], exp_d[k], 16'(k));
        end
      end
    end
    tests_run++;
    if (done_cnt - db !== 1 || done_cyc !== last_wr_cyc + 1) begin
      fails++;
      $display("FAIL %s_done: pulses=%0d done_cyc=%0d last_wr=%0d, expected 1 pulse one cycle after",
               name, done_cnt - db, done_cyc, last_wr_cyc);
    end
    tests_run++;
    if (checksum !== 16'hBCCF) begin
      fails++;
      $display("FAIL %s_checksum: got %h, expected bccf", name, checksum);
    end
  endtask

  task automatic load_three_stim();
    stim.delete();
    stim = '{8'h92, 8'h05, 8'h94, 8'h3B, 8'h96, 8'h8F};
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; load_len = 9'd0; byte_in = 8'h00; byte_valid = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({byte_ready, wr_en, busy, done} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b, expected 0000", {byte_ready, wr_en, busy, done});
    end
    tests_run++;
    if (wr_addr !== 16'h0 || wr_data !== 16'h0 || checksum !== 16'h0) begin
      fails++;
      $display("FAIL reset_data: addr=%h data=%h sum=%h, expected 0", wr_addr, wr_data, checksum);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (byte_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignore_valid: ready=%b busy=%b, expected 0 0", byte_ready, busy);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_three_word();
    int wb = wa_q.size();
    int db = done_cnt;
    load_three_stim();
    start_load(9'd3);
    tests_run++;
    if (byte_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_latency: ready=%b busy=%b, expected 1 1", byte_ready, busy);
    end
    stream(6, 0);
    wait_done(20);
    check_three("three", wb, db);
  endtask

  task automatic test_backpressure();
    int wb = wa_q.size();
    int db = done_cnt;
    int rv = rdy_viol;
    load_three_stim();
    start_load(9'd3);
    stream(6, 1);
    wait_done(20);
    check_three("gaps", wb, db);
    tests_run++;
    if (rdy_viol !== rv) begin
      fails++;
      $display("FAIL gaps_ready: %0d cycles with ready in WRITE/DONE, expected 0", rdy_viol - rv);
    end
  endtask

  task automatic test_zero_len();
    int wb = wa_q.size();
    start_load(9'd0);
    tests_run++;
    if (done !== 1'b1 || checksum !== 16'h0 || byte_ready !== 1'b0) begin
      fails++;
      $display("FAIL zero_len: done=%b sum=%h ready=%b, expected 1 0000 0", done, checksum, byte_ready);
    end
    wait_done(2);
    tests_run++;
    if (wa_q.size() !== wb) begin
      fails++;
      $display("FAIL zero_len_wr: got %0d writes, expected 0", wa_q.size() - wb);
    end
  endtask

  task automatic test_clamp();
    int wb = wa_q.size();
    int bad = 0;
    logic [15:0] exp_sum = 16'h0;
    stim.delete();
    for (int i = 0; i < 512; i++) stim.push_back(8'(i));
    for (int k = 0; k < 256; k++) exp_sum = exp_sum + {8'(2*k), 8'(2*k+1)};
    start_load(9'd300);
    stream(512, 0);
    wait_done(20);
    tests_run++;
    if (wa_q.size() - wb !== 256) begin
      fails++;
      $display("FAIL clamp_nwr: got %0d writes, expected 256", wa_q.size() - wb);
    end else begin
      for (int k = 0; k < 256; k++)
        if (wa_q[wb+k] !== 16'(k) || wd_q[wb+k] !== {8'(2*k), 8'(2*k+1)}) bad++;
      tests_run++;
      if (bad !== 0) begin
        fails++;
        $display("FAIL clamp_writes: %0d bad writes, expected 0", bad);
      end
      tests_run++;
      if (wa_q[wb+255] !== 16'h00FF) begin
        fails++;
        $display("FAIL clamp_last_addr: got %h, expected 00ff", wa_q[wb+255]);
      end
    end
    tests_run++;
    if (checksum !== exp_sum) begin
      fails++;
      $display("FAIL clamp_checksum: got %h, expected %h", checksum, exp_sum);
    end
  endtask

  task automatic test_ignored_start();
    int wb = wa_q.size();
    int db = done_cnt;
    load_three_stim();
    start_load(9'd3);
    stream(6, 2);
    wait_done(20);
    check_three("ignstart", wb, db);
  endtask

  task automatic test_reset_mid();
    int wb = wa_q.size();
    int db = done_cnt;
    load_three_stim();
    start_load(9'd3);
    stream(3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({byte_ready, wr_en, busy, done} !== 4'b0000 || wr_addr !== 16'h0 ||
        wr_data !== 16'h0 || checksum !== 16'h0) begin
      fails++;
      $display("FAIL midrst_outputs: flags=%b addr=%h data=%h sum=%h, expected all 0",
               {byte_ready, wr_en, busy, done}, wr_addr, wr_data, checksum);
    end
    repeat (10) tick();
    tests_run++;
    if (wa_q.size() - wb !== 1 || done_cnt !== db) begin
      fails++;
      $display("FAIL midrst_abort: writes=%0d dones=%0d, expected 1 0", wa_q.size() - wb, done_cnt - db);
    end
    wb = wa_q.size();
    stim.delete();
    stim = '{8'h00, 8'h00};
    start_load(9'd1);
    stream(2, 0);
    wait_done(20);
    tests_run++;
    if (wa_q.size() - wb !== 1 || wa_q[wb] !== 16'h0 || wd_q[wb] !== 16'h0 || checksum !== 16'h0) begin
      fails++;
      $display("FAIL midrst_reload: writes=%0d sum=%h, expected 1 write 0000@0000 sum 0000",
               wa_q.size() - wb, checksum);
    end
  endtask

  task automatic test_wrap();
    stim.delete();
    stim = '{8'hFF, 8'hFF, 8'h00, 8'h02};
    start_load(9'd2);
    stream(4, 0);
    wait_done(20);
    tests_run++;
    if (checksum !== 16'h0001) begin
      fails++;
      $display("FAIL wrap_checksum: got %h, expected 0001", checksum);
    end
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_backpressure();
    test_zero_len();
    test_clamp();
    test_ignored_start();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
